fpu_req_arbiter: RTL and testbench
==================================

# fpu_req_arbiter

Two-port request arbiter and sequencer for the shared FPU datapath. It accepts operand pairs from two independent requesters, grants the FPU round-robin, and issues one start pulse per accepted request. It waits for FPU completion and returns the result word and status to the granted requester over a valid/ready response channel. It sits between the requester logic (control units) and the single FPU instance, so the FPU never sees overlapping operations.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 64: maximum cycles spent in WAIT before the operation is aborted (only with the timeout feature compiled in). Legal range 2..255.

Ports:
- `clock_100Khz`  in  1  single system clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  2  per-requester request valid (bit i = requester i).
- `req_op_a`  in  2x32  operand A per requester (sign[31], exponent[30:21] bias 511, fraction[20:0]).
- `req_op_b`  in  2x32  operand B per requester, same format.
- `req_ready`  out  2  one-hot accept strobe; request transfers when `req_valid[i] && req_ready[i]`.
- `fpu_start`  out  1  single-cycle pulse starting the FPU.
- `fpu_op_a`  out  32  latched operand A, stable from ISSUE until return to IDLE.
- `fpu_op_b`  out  32  latched operand B, same stability rule.
- `fpu_done`  in  1  FPU completion pulse; sampled only in WAIT.
- `fpu_data`  in  32  FPU result, valid with `fpu_done`.
- `fpu_status`  in  4  FPU status: 0 OVERFLOW, 1 UNDERFLOW, 2 EXACT, 3 INEXACT.
- `rsp_valid`  out  2  one-hot response valid toward the granted requester.
- `rsp_data`  out  32  captured result.
- `rsp_status`  out  4  captured status; 4'hF = TIMEOUT.
- `rsp_ready`  in  2  per-requester response accept.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESPOND (2-bit encoding).
- IDLE:
  - If any `req_valid` is set, select the requester by round-robin.
  - Assert `req_ready[sel]` combinationally that cycle and latch its operands. Next state is ISSUE.
- Round-robin uses a 1-bit priority pointer `prio`.
  - If both requesters are valid, `prio` wins.
  - If only one is valid, it wins regardless of `prio`.
  - `prio` is set to the other requester only on response handshake.
- ISSUE: `fpu_start`=1 for exactly this cycle, clear the timeout counter. Next state is WAIT.
- WAIT:
  - On `fpu_done`, capture `fpu_data` and `fpu_status`. Next state is RESPOND.
  - `fpu_done` outside WAIT is ignored.
- RESPOND:
  - `rsp_valid[grant]`=1 with `rsp_data` and `rsp_status` held stable.
  - On `rsp_ready[grant]`, go to IDLE and toggle `prio` away from `grant`.
  - `rsp_ready` of the non-granted port is ignored.
- Requests that arrive while `busy` are not accepted (`req_ready`=0). Requesters must hold `req_valid` and operands stable until accepted.
- Reset asserted mid-operation:
  - FSM returns to IDLE immediately; any in-flight FPU result is discarded.
  - No `rsp_valid` is raised for the aborted request.

## Timing
- Reset values:
  - FSM=IDLE, `prio`=0.
  - `req_ready`=0, `fpu_start`=0, `rsp_valid`=0, `busy`=0.
  - `fpu_op_a`, `fpu_op_b`, `rsp_data` = 32'h0; `rsp_status`=4'h2 (EXACT).
- Acceptance to `fpu_start`: 1 cycle. `fpu_done` at cycle n after `fpu_start` gives `rsp_valid` at cycle n+1.
- Minimum occupancy with a 1-cycle FPU and `rsp_ready` tied high: 4 cycles per operation (IDLE, ISSUE, WAIT, RESPOND).
- `fpu_done` in the same cycle as `fpu_start` is not sampled; the earliest sampled done is one cycle after ISSUE.
- Back-to-back: after the RESPOND handshake, IDLE can accept in the next cycle.

## Configuration
- `FPU_ARB_TIMEOUT_EN` defined:
  - An 8-bit counter runs in WAIT.
  - When it reaches `TIMEOUT_CYCLES` with no `fpu_done`, capture `rsp_data`=32'h0 and `rsp_status`=4'hF, then go to RESPOND.
  - `fpu_done` on the same edge as expiry wins and is captured normally.
- Not defined: no counter; WAIT holds indefinitely until `fpu_done`; status 4'hF is never produced.

## Test plan
- Single request:
  - Stimulus: req0 A=32'h3FE00000 (1.0), B=32'h3FE00000; FPU model returns 32'h40000000 (2.0), status 2, three cycles after start; `rsp_ready` high.
  - Required: `req_ready[0]` for one cycle, one `fpu_start` pulse, `rsp_valid[0]` with data 32'h40000000 and status 2 exactly 4 cycles after `fpu_start`.
- Contention: both requesters valid continuously from reset -> grants alternate 0,1,0,1 over four operations, and each response goes to the matching port only.
- Response backpressure: `rsp_ready[0]` held low for 10 cycles -> `rsp_valid[0]`, `rsp_data` and `rsp_status` stable throughout; no new `req_ready` while blocked.
- Spurious done: pulse `fpu_done` while in IDLE and again in RESPOND -> no state change and no data overwrite.
- Reset mid-WAIT: assert `reset` two cycles after `fpu_start` -> all outputs at reset values immediately; no `rsp_valid` after release; next request is granted to requester 0.
- Timeout (`FPU_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8): FPU never asserts done -> `rsp_valid` with data 32'h0 and status 4'hF, 9 cycles after `fpu_start`.

Source files
------------

// File: rtl/fpu_req_arbiter_if.sv
// Handshake bundle between the two requesters, the FPU request arbiter and the shared FPU.
// The slave modport is the arbiter's view; the master modport is the requester/FPU side.
interface fpu_req_arbiter_if;
  logic [1:0]        req_valid;
  logic [1:0][31:0]  req_op_a;
  logic [1:0][31:0]  req_op_b;
  logic [1:0]        req_ready;

  logic              fpu_start;
  logic [31:0]       fpu_op_a;
  logic [31:0]       fpu_op_b;
  logic              fpu_done;
  logic [31:0]       fpu_data;
  logic [3:0]        fpu_status;

  logic [1:0]        rsp_valid;
  logic [31:0]       rsp_data;
  logic [3:0]        rsp_status;
  logic [1:0]        rsp_ready;

  logic              busy;

  modport slave (
    input  req_valid, req_op_a, req_op_b,
    input  fpu_done, fpu_data, fpu_status,
    input  rsp_ready,
    output req_ready,
    output fpu_start, fpu_op_a, fpu_op_b,
    output rsp_valid, rsp_data, rsp_status,
    output busy
  );

  modport master (
    output req_valid, req_op_a, req_op_b,
    output fpu_done, fpu_data, fpu_status,
    output rsp_ready,
    input  req_ready,
    input  fpu_start, fpu_op_a, fpu_op_b,
    input  rsp_valid, rsp_data, rsp_status,
    input  busy
  );
endinterface

// File: rtl/fpu_req_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared FPU: accept, issue, wait, respond.
// Optional WAIT timeout is compiled in with `define FPU_ARB_TIMEOUT_EN.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no operation; accept the round-robin winner, latch operands
// ISSUE   | one-cycle fpu_start pulse, timeout counter loaded
// WAIT    | waiting for fpu_done (or timeout expiry)
// RESPOND | rsp_valid to granted port until its rsp_ready
module fpu_req_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clock_100Khz,
  input  logic                reset,
  fpu_req_arbiter_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  state_t      state, state_nxt;
  logic        prio;
  logic        grant;
  logic        sel;
  logic        accept;
  logic        cap_done;
  logic        cap_tmo;
  logic        rsp_hs;
  logic        tmr_expired;
  logic [31:0] op_a_q, op_b_q;
  logic [31:0] rsp_data_q;
  logic [3:0]  rsp_status_q;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("fpu_req_arbiter: TIMEOUT_CYCLES must be in 2..255");
  end

  // A lone requester wins outright; prio only breaks ties.
  always_comb begin
    sel = prio;
    if (bus.req_valid == 2'b01)
      sel = 1'b0;
    else if (bus.req_valid == 2'b10)
      sel = 1'b1;
  end

  always_ff @(posedge clock_100Khz or posedge reset) begin
    if (reset)
      state <= S_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.req_ready = 2'b00;
    bus.fpu_start = 1'b0;
    bus.rsp_valid = 2'b00;
    accept        = 1'b0;
    cap_done      = 1'b0;
    cap_tmo       = 1'b0;
    rsp_hs        = 1'b0;
    case (state)
      S_IDLE: begin
        if (|bus.req_valid) begin
          bus.req_ready[sel] = 1'b1;
          accept             = 1'b1;
          state_nxt          = S_ISSUE;
        end
      end
      S_ISSUE: begin
        bus.fpu_start = 1'b1;
        state_nxt     = S_WAIT;
      end
      S_WAIT: begin
        // A done arriving on the expiry edge still carries a real result.
        if (bus.fpu_done) begin
          cap_done  = 1'b1;
          state_nxt = S_RESPOND;
        end else if (tmr_expired) begin
          cap_tmo   = 1'b1;
          state_nxt = S_RESPOND;
        end
      end
      S_RESPOND: begin
        bus.rsp_valid[grant] = 1'b1;
        if (bus.rsp_ready[grant]) begin
          rsp_hs    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_100Khz or posedge reset) begin
    if (reset) begin
      prio         <= 1'b0;
      grant        <= 1'b0;
      op_a_q       <= 32'h0;
      op_b_q       <= 32'h0;
      rsp_data_q   <= 32'h0;
      rsp_status_q <= 4'h2;
    end else begin
      if (accept) begin
        grant  <= sel;
        op_a_q <= bus.req_op_a[sel];
        op_b_q <= bus.req_op_b[sel];
      end
      if (cap_done) begin
        rsp_data_q   <= bus.fpu_data;
        rsp_status_q <= bus.fpu_status;
      end else if (cap_tmo) begin
        rsp_data_q   <= 32'h0;
        rsp_status_q <= 4'hF;
      end
      if (rsp_hs)
        prio <= ~grant;
    end
  end

`ifdef FPU_ARB_TIMEOUT_EN
  // Down-counter loaded in ISSUE; terminal count 0 gives TIMEOUT_CYCLES WAIT cycles.
  localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmr_cnt;

  always_ff @(posedge clock_100Khz or posedge reset) begin
    if (reset)
      tmr_cnt <= 8'd0;
    else if (state == S_ISSUE)
      tmr_cnt <= TMR_LOAD;
    else if (state == S_WAIT && tmr_cnt != 8'd0)
      tmr_cnt <= tmr_cnt - 8'd1;
  end

  assign tmr_expired = (tmr_cnt == 8'd0);
`else
  assign tmr_expired = 1'b0;
`endif

  assign bus.fpu_op_a   = op_a_q;
  assign bus.fpu_op_b   = op_b_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_status = rsp_status_q;
  assign bus.busy       = (state != S_IDLE);

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed self-checking bench for fpu_req_arbiter; the timeout scenario runs only
// when FPU_ARB_TIMEOUT_EN is defined.
module tb_fpu_req_arbiter;
  logic clock_100Khz;
  logic reset;
  int   errors;
  int   checks;

  fpu_req_arbiter_if bus ();

  fpu_req_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clock_100Khz (clock_100Khz),
    .reset        (reset),
    .bus          (bus)
  );

  initial clock_100Khz = 1'b0;
  always #5 clock_100Khz = ~clock_100Khz;

  task automatic tick();
    @(posedge clock_100Khz);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid  = 2'b00;
    bus.req_op_a   = '0;
    bus.req_op_b   = '0;
    bus.fpu_done   = 1'b0;
    bus.fpu_data   = 32'h0;
    bus.fpu_status = 4'h0;
    bus.rsp_ready  = 2'b11;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready); end
    checks++; if (bus.fpu_start !== 1'b0) begin errors++; $display("FAIL reset_fpu_start got=%b exp=0", bus.fpu_start); end
    checks++; if (bus.rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got=%b exp=00", bus.rsp_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.fpu_op_a !== 32'h0) begin errors++; $display("FAIL reset_fpu_op_a got=%h exp=0", bus.fpu_op_a); end
    checks++; if (bus.fpu_op_b !== 32'h0) begin errors++; $display("FAIL reset_fpu_op_b got=%h exp=0", bus.fpu_op_b); end
    checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL reset_rsp_data got=%h exp=0", bus.rsp_data); end
    checks++; if (bus.rsp_status !== 4'h2) begin errors++; $display("FAIL reset_rsp_status got=%h exp=2", bus.rsp_status); end
    reset = 1'b0;
  endtask

  task automatic test_single();
    logic [1:0] exp_v;
    int starts;
    starts = 0;
    bus.req_op_a[0] = 32'h3FE00000;
    bus.req_op_b[0] = 32'h3FE00000;
    bus.req_valid   = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL single_accept got=%b exp=01", bus.req_ready); end
    tick();
    checks++; if (bus.req_ready !== 2'b00) begin errors++; $display("FAIL single_ready_once got=%b exp=00", bus.req_ready); end
    checks++; if (bus.fpu_start !== 1'b1) begin errors++; $display("FAIL single_start got=%b exp=1", bus.fpu_start); end
    checks++; if (bus.fpu_op_a !== 32'h3FE00000) begin errors++; $display("FAIL single_op_a got=%h exp=3fe00000", bus.fpu_op_a); end
    if (bus.fpu_start === 1'b1) starts++;
    bus.req_valid = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      tick();
      bus.fpu_done   = (k == 3);
      bus.fpu_data   = (k == 3) ? 32'h40000000 : 32'h0;
      bus.fpu_status = (k == 3) ? 4'h2 : 4'h0;
      if (bus.fpu_start === 1'b1) starts++;
      exp_v = (k == 4) ? 2'b01 : 2'b00;
      checks++; if (bus.rsp_valid !== exp_v) begin errors++; $display("FAIL single_rsp_valid_k%0d got=%b exp=%b", k, bus.rsp_valid, exp_v); end
    end
    checks++; if (bus.rsp_data !== 32'h40000000) begin errors++; $display("FAIL single_rsp_data got=%h exp=40000000", bus.rsp_data); end
    checks++; if (bus.rsp_status !== 4'h2) begin errors++; $display("FAIL single_rsp_status got=%h exp=2", bus.rsp_status); end
    tick();
    checks++; if (starts !== 1) begin errors++; $display("FAIL single_start_count got=%0d exp=1", starts); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_back_idle got=%b exp=0", bus.busy); end
  endtask

  task automatic test_contention();
    logic        g;
    logic [1:0]  exp_oh;
    logic [31:0] exp_a;
    idle_inputs();
    bus.req_op_a[0] = 32'hA0A0_0000;
    bus.req_op_a[1] = 32'hB1B1_0001;
    bus.req_op_b[0] = 32'h0000_00A0;
    bus.req_op_b[1] = 32'h0000_00B1;
    bus.req_valid   = 2'b11;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      g      = (i % 2) == 1;
      exp_oh = g ? 2'b10 : 2'b01;
      exp_a  = g ? 32'hB1B1_0001 : 32'hA0A0_0000;
      checks++; if (bus.req_ready !== exp_oh) begin errors++; $display("FAIL contention_grant%0d got=%b exp=%b", i, bus.req_ready, exp_oh); end
      tick();
      checks++; if (bus.fpu_op_a !== exp_a) begin errors++; $display("FAIL contention_op_a%0d got=%h exp=%h", i, bus.fpu_op_a, exp_a); end
      tick();
      bus.fpu_done   = 1'b1;
      bus.fpu_data   = 32'h100 + i;
      bus.fpu_status = 4'h3;
      tick();
      bus.fpu_done = 1'b0;
      checks++; if (bus.rsp_valid !== exp_oh) begin errors++; $display("FAIL contention_rsp_port%0d got=%b exp=%b", i, bus.rsp_valid, exp_oh); end
      checks++; if (bus.rsp_data !== 32'h100 + i) begin errors++; $display("FAIL contention_rsp_data%0d got=%h exp=%h", i, bus.rsp_data, 32'h100 + i); end
      tick();
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_backpressure();
    idle_inputs();
    do_reset();
    bus.rsp_ready   = 2'b00;
    bus.req_op_a[0] = 32'h0000_0011;
    bus.req_valid   = 2'b01;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL bp_accept got=%b exp=01", bus.req_ready); end
    tick();
    bus.req_valid = 2'b10;
    tick();
    bus.fpu_done   = 1'b1;
    bus.fpu_data   = 32'hCAFE_0001;
    bus.fpu_status = 4'h8;
    tick();
    bus.fpu_done   = 1'b0;
    bus.fpu_data   = 32'h0;
    bus.fpu_status = 4'h0;
    bus.rsp_ready  = 2'b10;
    for (int k = 0; k < 10; k++) begin
      checks++;
      if ({bus.rsp_valid, bus.rsp_data, bus.rsp_status, bus.req_ready} !== {2'b01, 32'hCAFE_0001, 4'h8, 2'b00}) begin
        errors++;
        $display("FAIL bp_hold_c%0d got valid=%b data=%h status=%h ready=%b exp valid=01 data=cafe0001 status=8 ready=00",
                 k, bus.rsp_valid, bus.rsp_data, bus.rsp_status, bus.req_ready);
      end
      tick();
    end
    bus.rsp_ready = 2'b01;
    tick();
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL bp_release_accept got=%b exp=10", bus.req_ready); end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_spurious_done();
    idle_inputs();
    do_reset();
    bus.fpu_done   = 1'b1;
    bus.fpu_data   = 32'hDEAD_BEEF;
    bus.fpu_status = 4'h1;
    tick();
    bus.fpu_done = 1'b0;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL spur_idle_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL spur_idle_data got=%h exp=0", bus.rsp_data); end
    checks++; if (bus.rsp_status !== 4'h2) begin errors++; $display("FAIL spur_idle_status got=%h exp=2", bus.rsp_status); end
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    tick();
    bus.fpu_done   = 1'b1;
    bus.fpu_data   = 32'h1234_5678;
    bus.fpu_status = 4'h3;
    bus.rsp_ready  = 2'b00;
    tick();
    bus.fpu_data   = 32'hBAD0_BAD0;
    bus.fpu_status = 4'h1;
    tick();
    bus.fpu_done = 1'b0;
    checks++; if (bus.rsp_valid !== 2'b01) begin errors++; $display("FAIL spur_rsp_state got=%b exp=01", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 32'h1234_5678) begin errors++; $display("FAIL spur_rsp_data got=%h exp=12345678", bus.rsp_data); end
    checks++; if (bus.rsp_status !== 4'h3) begin errors++; $display("FAIL spur_rsp_status got=%h exp=3", bus.rsp_status); end
    bus.rsp_ready = 2'b01;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL spur_done_idle got=%b exp=0", bus.busy); end
  endtask

  // Runs after a requester-0 handshake, so prio points at requester 1 going in.
  task automatic test_reset_mid_wait();
    bus.req_op_a[1] = 32'h7777_0001;
    bus.req_valid   = 2'b10;
    #1;
    checks++; if (bus.req_ready !== 2'b10) begin errors++; $display("FAIL rmw_accept got=%b exp=10", bus.req_ready); end
    tick();
    checks++; if (bus.fpu_start !== 1'b1) begin errors++; $display("FAIL rmw_start got=%b exp=1", bus.fpu_start); end
    bus.req_valid = 2'b00;
    tick();
    tick();
    reset          = 1'b1;
    bus.fpu_done   = 1'b1;
    bus.fpu_data   = 32'h5555_5555;
    bus.fpu_status = 4'h3;
    #1;
    checks++;
    if ({bus.busy, bus.fpu_start, bus.rsp_valid, bus.req_ready, bus.fpu_op_a, bus.rsp_data, bus.rsp_status}
        !== {1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 4'h2}) begin
      errors++;
      $display("FAIL rmw_reset_outputs got busy=%b start=%b rv=%b rr=%b opa=%h data=%h status=%h exp all reset values",
               bus.busy, bus.fpu_start, bus.rsp_valid, bus.req_ready, bus.fpu_op_a, bus.rsp_data, bus.rsp_status);
    end
    tick();
    bus.fpu_done = 1'b0;
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.rsp_valid !== 2'b00 || bus.busy !== 1'b0) begin errors++; $display("FAIL rmw_no_rsp_c%0d got rv=%b busy=%b exp rv=00 busy=0", k, bus.rsp_valid, bus.busy); end
    end
    bus.req_valid = 2'b11;
    #1;
    checks++; if (bus.req_ready !== 2'b01) begin errors++; $display("FAIL rmw_next_grant got=%b exp=01", bus.req_ready); end
    bus.req_valid = 2'b00;
  endtask

`ifdef FPU_ARB_TIMEOUT_EN
  task automatic test_timeout();
    logic [1:0] exp_v;
    idle_inputs();
    do_reset();
    bus.req_valid = 2'b01;
    tick();
    bus.req_valid = 2'b00;
    checks++; if (bus.fpu_start !== 1'b1) begin errors++; $display("FAIL tmo_start got=%b exp=1", bus.fpu_start); end
    for (int k = 1; k <= 9; k++) begin
      tick();
      exp_v = (k == 9) ? 2'b01 : 2'b00;
      checks++; if (bus.rsp_valid !== exp_v) begin errors++; $display("FAIL tmo_rsp_valid_k%0d got=%b exp=%b", k, bus.rsp_valid, exp_v); end
    end
    checks++; if (bus.rsp_data !== 32'h0) begin errors++; $display("FAIL tmo_rsp_data got=%h exp=0", bus.rsp_data); end
    checks++; if (bus.rsp_status !== 4'hF) begin errors++; $display("FAIL tmo_rsp_status got=%h exp=f", bus.rsp_status); end
    tick();
  endtask
`endif

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b0;
    idle_inputs();
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_spurious_done();
    test_reset_mid_wait();
`ifdef FPU_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
